// File: rtl/fsm_moore_packer.sv
// Packs sealed products into boxes of BOX_SIZE with a small pending queue and a Moore FSM.
// Optional PACKER_BOX_COUNTER_EN adds a wrapping count of completed (removed) boxes.
module fsm_moore_packer #(
  parameter int unsigned BOX_SIZE     = 4,
  parameter int unsigned PLACE_CYCLES = 3,
  parameter int unsigned QUEUE_DEPTH  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sellando,
  input  logic       box_present,
  input  logic       box_removed,
  output logic       empacando,
  output logic       box_full,
  output logic       overflow,
  output logic [1:0] pending,
  output logic [2:0] box_count,
  output logic [2:0] state_indicator
`ifdef PACKER_BOX_COUNTER_EN
  ,
  output logic [7:0] boxes_done
`endif
);

  // Encodings double as the state_indicator values.
  typedef enum logic [2:0] {
    StIdle    = 3'b000,
    StWaitBox = 3'b001,
    StPlace   = 3'b010,
    StFull    = 3'b011,
    StFault   = 3'b100
  } state_e;

  localparam logic [1:0] QueueMax  = 2'(QUEUE_DEPTH);
  localparam logic [2:0] BoxLast   = 3'(BOX_SIZE - 1);
  localparam logic [3:0] TimerLoad = 4'(PLACE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [2:0] box_count_q, box_count_d;
  logic [1:0] pending_q, pending_d;
  logic       overflow_q, overflow_d;
  logic       sellando_q;
  logic       seal_evt;
  logic       take;

  assign seal_evt = sellando_q & ~sellando;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    box_count_d = box_count_q;
    take        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q != 2'd0) begin
          if (box_present) begin
            state_d = StPlace;
            take    = 1'b1;
          end else begin
            state_d = StWaitBox;
          end
        end
      end
      StWaitBox: begin
        if (box_present) begin
          state_d = StPlace;
          take    = 1'b1;
        end
      end
      StPlace: begin
        // Losing the box drops the product in hand and empties the count.
        if (!box_present) begin
          state_d     = StFault;
          box_count_d = 3'd0;
        end else if (timer_q == 4'd0) begin
          box_count_d = box_count_q + 3'd1;
          state_d     = (box_count_q == BoxLast) ? StFull : StIdle;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      StFull: begin
        if (box_removed) begin
          state_d     = StIdle;
          box_count_d = 3'd0;
        end
      end
      StFault: begin
        if (box_present) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (take) timer_d = TimerLoad;
  end

  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (seal_evt && !take) begin
      if (pending_q == QueueMax) overflow_d = 1'b1;
      else                       pending_d  = pending_q + 2'd1;
    end else if (!seal_evt && take) begin
      pending_d = pending_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= 4'd0;
      box_count_q <= 3'd0;
      pending_q   <= 2'd0;
      overflow_q  <= 1'b0;
      sellando_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      box_count_q <= box_count_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      sellando_q  <= sellando;
    end
  end

  assign empacando       = (state_q == StPlace);
  assign box_full        = (state_q == StFull);
  assign overflow        = overflow_q;
  assign pending         = pending_q;
  assign box_count       = box_count_q;
  assign state_indicator = state_q;

`ifdef PACKER_BOX_COUNTER_EN
  logic       box_done;
  logic [7:0] boxes_done_q;

  assign box_done = (state_q == StFull) && box_removed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           boxes_done_q <= 8'd0;
    else if (box_done) boxes_done_q <= boxes_done_q + 8'd1;
  end

  assign boxes_done = boxes_done_q;
`endif

endmodule

// File: tb/tb_fsm_moore_packer.sv
// Bench for fsm_moore_packer: directed scenarios with literal expectations plus random traffic
// checked every cycle against a behavioural model of the packing rules.
module tb_fsm_moore_packer;

  localparam int BoxSize     = 4;
  localparam int PlaceCycles = 3;
  localparam int QueueDepth  = 3;

  localparam int MIdle  = 0;
  localparam int MWait  = 1;
  localparam int MPlace = 2;
  localparam int MFull  = 3;
  localparam int MFault = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sellando = 1'b0;
  logic       box_present = 1'b0;
  logic       box_removed = 1'b0;
  logic       empacando, box_full, overflow;
  logic [1:0] pending;
  logic [2:0] box_count, state_indicator;
`ifdef PACKER_BOX_COUNTER_EN
  logic [7:0] boxes_done;
`endif

  fsm_moore_packer #(
    .BOX_SIZE    (BoxSize),
    .PLACE_CYCLES(PlaceCycles),
    .QUEUE_DEPTH (QueueDepth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sellando       (sellando),
    .box_present    (box_present),
    .box_removed    (box_removed),
    .empacando      (empacando),
    .box_full       (box_full),
    .overflow       (overflow),
    .pending        (pending),
    .box_count      (box_count),
    .state_indicator(state_indicator)
`ifdef PACKER_BOX_COUNTER_EN
    ,
    .boxes_done     (boxes_done)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: mode, queued products, products in box, PLACE cycles still to go, sticky drop flag.
  int m_mode  = MIdle;
  int m_pend  = 0;
  int m_cnt   = 0;
  int m_left  = 0;
  int m_boxes = 0;
  bit m_ovf   = 1'b0;
  bit m_prev  = 1'b0;

  task automatic model_step();
    bit seal;
    bit take;
    seal   = m_prev && !sellando;
    m_prev = sellando;
    take   = 1'b0;
    case (m_mode)
      MIdle:  if (m_pend > 0) begin
                if (box_present) take = 1'b1;
                else             m_mode = MWait;
              end
      MWait:  if (box_present) take = 1'b1;
      MPlace: if (!box_present) begin
                m_mode = MFault;
                m_cnt  = 0;
              end else begin
                m_left--;
                if (m_left == 0) begin
                  m_cnt++;
                  m_mode = (m_cnt == BoxSize) ? MFull : MIdle;
                end
              end
      MFull:  if (box_removed) begin
                m_mode  = MIdle;
                m_cnt   = 0;
                m_boxes = (m_boxes + 1) % 256;
              end
      MFault: if (box_present) m_mode = MIdle;
      default: m_mode = MIdle;
    endcase
    if (take) begin
      m_mode = MPlace;
      m_left = PlaceCycles;
    end
    if (seal && !take && m_pend == QueueDepth) m_ovf = 1'b1;
    else m_pend = m_pend + int'(seal) - int'(take);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = MIdle; m_pend = 0; m_cnt = 0; m_left = 0; m_boxes = 0;
      m_ovf = 1'b0; m_prev = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("state", int'(state_indicator), m_mode);
      chk("empacando", int'(empacando), int'(m_mode == MPlace));
      chk("box_full", int'(box_full), int'(m_mode == MFull));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("pending", int'(pending), m_pend);
      chk("box_count", int'(box_count), m_cnt);
`ifdef PACKER_BOX_COUNTER_EN
      chk("boxes_done", int'(boxes_done), m_boxes);
`endif
    end
  end

  // Called at a negedge; applies inputs for one full cycle.
  task automatic tick(input logic s, input logic bp, input logic br);
    sellando    = s;
    box_present = bp;
    box_removed = br;
    @(negedge clk);
  endtask

  task automatic product(input logic bp, input int gap);
    tick(1'b1, bp, 1'b0);
    repeat (gap - 1) tick(1'b0, bp, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, int'(state_indicator), 0);
    chk({tag, "_empacando"}, int'(empacando), 0);
    chk({tag, "_box_full"}, int'(box_full), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_pending"}, int'(pending), 0);
    chk({tag, "_box_count"}, int'(box_count), 0);
  endtask

  task automatic do_reset(input bit check_now);
    #2;
    rst = 1'b1; sellando = 1'b0; box_present = 1'b0; box_removed = 1'b0;
    #1;
    if (check_now) check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp_pend[4] = '{1, 2, 3, 3};

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Seal-to-PLACE latency, then reset while placing.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk("lat_pending", int'(pending), 1);
    chk("lat_emp_low", int'(empacando), 0);
    tick(1'b0, 1'b1, 1'b0);
    chk("lat_emp_high", int'(empacando), 1);
    chk("lat_state", int'(state_indicator), 2);
    do_reset(1'b1);

    // One full box, then removal.
    for (int k = 1; k <= 4; k++) begin
      product(1'b1, 10);
      if (k < 4) chk("fill_count", int'(box_count), k);
    end
    chk("full_flag", int'(box_full), 1);
    chk("full_state", int'(state_indicator), 3);
    chk("full_count", int'(box_count), 4);
    tick(1'b0, 1'b1, 1'b1);
    chk("removed_state", int'(state_indicator), 0);
    chk("removed_count", int'(box_count), 0);

    // No box: queue fills and overflows.
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk("queue_pending", int'(pending), exp_pend[k]);
      chk("queue_overflow", int'(overflow), int'(k == 3));
    end
    chk("wait_state", int'(state_indicator), 1);
    tick(1'b0, 1'b1, 1'b0);
    chk("wait_place_state", int'(state_indicator), 2);
    chk("wait_place_pending", int'(pending), 2);
    repeat (20) tick(1'b0, 1'b1, 1'b0);
    chk("drain_count", int'(box_count), 3);
    do_reset(1'b0);

    // Seal coinciding with PLACE entry, then a fault on the second PLACE cycle.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("coin_pre_state", int'(state_indicator), 0);
    chk("coin_pre_pending", int'(pending), 1);
    tick(1'b0, 1'b1, 1'b0);
    chk("coin_state", int'(state_indicator), 2);
    chk("coin_pending", int'(pending), 1);
    chk("coin_overflow", int'(overflow), 0);
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    chk("pre_fault_count", int'(box_count), 2);
    tick(1'b0, 1'b0, 1'b0);
    chk("fault_state", int'(state_indicator), 4);
    chk("fault_count", int'(box_count), 0);
    chk("fault_emp", int'(empacando), 0);
    tick(1'b0, 1'b1, 1'b0);
    chk("fault_exit_state", int'(state_indicator), 0);

`ifdef PACKER_BOX_COUNTER_EN
    do_reset(1'b0);
    for (int b = 0; b < 3; b++) begin
      repeat (4) product(1'b1, 10);
      tick(1'b0, 1'b1, 1'b1);
    end
    tick(1'b0, 1'b1, 1'b0);
    chk("boxes_done_3", int'(boxes_done), 3);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    chk("boxes_done_idle_rm", int'(boxes_done), 3);
`endif

    // Random traffic against the model.
    do_reset(1'b0);
    begin
      logic s;
      s = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 2) == 0) s = ~s;
        tick(s, logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 7) == 0));
      end
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
